// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one memory port between IF, MR and MW requesters (MW > MR > IF).
// Optional fetch anti-starvation aging enabled with `define ARB_FETCH_AGE_EN.
module mem_port_arbiter #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int AGE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              r,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_cancel,
   input  logic              mr_req,
   input  logic [ADDR_W-1:0] mr_addr,
   input  logic              mw_req,
   input  logic [ADDR_W-1:0] mw_addr,
   input  logic [DATA_W-1:0] mw_wdata,
   output logic              if_done,
   output logic              mr_done,
   output logic              mw_done,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_done
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_MR, OWN_MW} owner_t;

   state_t            state_q;
   owner_t            owner_q;
   owner_t            grant_d;
   logic              cancel_q;
   logic              mem_req_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic              if_done_q;
   logic              mr_done_q;
   logic              mw_done_q;
   logic              if_elig;

   assign if_elig = if_req & ~if_cancel;

`ifdef ARB_FETCH_AGE_EN
   localparam int AW = $clog2(AGE_LIMIT + 1);
   localparam logic [AW-1:0] AGE_MAX = AW'(AGE_LIMIT);

   logic [AW-1:0] age_q;

   always_comb begin
      grant_d = OWN_NONE;
      if (if_elig && (age_q == AGE_MAX)) grant_d = OWN_IF;
      else if (mw_req)                   grant_d = OWN_MW;
      else if (mr_req)                   grant_d = OWN_MR;
      else if (if_elig)                  grant_d = OWN_IF;
   end

   always_ff @(posedge clk or negedge r) begin
      if (!r) begin
         age_q <= '0;
      end else if (!if_req || if_cancel) begin
         age_q <= '0;
      end else if (state_q == S_IDLE) begin
         if (grant_d == OWN_IF)    age_q <= '0;
         else if (age_q != AGE_MAX) age_q <= age_q + AW'(1);
      end
   end
`else
   if (AGE_LIMIT < 1) begin : g_age_limit_invalid
   end

   always_comb begin
      grant_d = OWN_NONE;
      if (mw_req)       grant_d = OWN_MW;
      else if (mr_req)  grant_d = OWN_MR;
      else if (if_elig) grant_d = OWN_IF;
   end
`endif

   always_ff @(posedge clk or negedge r) begin
      if (!r) begin
         state_q     <= S_IDLE;
         owner_q     <= OWN_NONE;
         cancel_q    <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rdata_q     <= '0;
         if_done_q   <= 1'b0;
         mr_done_q   <= 1'b0;
         mw_done_q   <= 1'b0;
      end else begin
         if_done_q <= 1'b0;
         mr_done_q <= 1'b0;
         mw_done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               cancel_q <= 1'b0;
               if (grant_d != OWN_NONE) begin
                  owner_q   <= grant_d;
                  mem_req_q <= 1'b1;
                  mem_we_q  <= (grant_d == OWN_MW);
                  state_q   <= S_BUSY;
                  case (grant_d)
                     OWN_MW: begin
                        mem_addr_q  <= mw_addr;
                        mem_wdata_q <= mw_wdata;
                     end
                     OWN_MR:  mem_addr_q <= mr_addr;
                     default: mem_addr_q <= if_addr;
                  endcase
               end
            end
            S_BUSY: begin
               if ((owner_q == OWN_IF) && if_cancel) cancel_q <= 1'b1;
               if (mem_done) begin
                  mem_req_q <= 1'b0;
                  state_q   <= S_RESP;
                  case (owner_q)
                     OWN_MW: mw_done_q <= 1'b1;
                     OWN_MR: begin
                        mr_done_q <= 1'b1;
                        rdata_q   <= mem_rdata;
                     end
                     OWN_IF: begin
                        // a cancel seen on the completion cycle counts as well
                        if (!(cancel_q || if_cancel)) begin
                           if_done_q <= 1'b1;
                           rdata_q   <= mem_rdata;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            S_RESP: begin
               state_q  <= S_IDLE;
               owner_q  <= OWN_NONE;
               cancel_q <= 1'b0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // a redirect arriving in the response cycle still squashes the fetch
   assign if_done   = if_done_q & ~if_cancel;
   assign mr_done   = mr_done_q;
   assign mw_done   = mw_done_q;
   assign rdata     = rdata_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; inputs change and outputs are checked on negedge.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        r;
   logic        if_req, if_cancel, mr_req, mw_req;
   logic [31:0] if_addr, mr_addr, mw_addr, mw_wdata;
   logic        if_done, mr_done, mw_done;
   logic [31:0] rdata;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .AGE_LIMIT(2)) dut (
      .clk(clk), .r(r),
      .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
      .mr_req(mr_req), .mr_addr(mr_addr),
      .mw_req(mw_req), .mw_addr(mw_addr), .mw_wdata(mw_wdata),
      .if_done(if_done), .mr_done(mr_done), .mw_done(mw_done),
      .rdata(rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_done(mem_done)
   );

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic nclk();
      @(negedge clk);
   endtask

   task automatic chk_quiet(input string tag);
      chk1({tag, "_memreq"}, mem_req, 1'b0);
      chk32({tag, "_dones"}, {29'd0, if_done, mr_done, mw_done}, 32'd0);
   endtask

   // Called on the negedge right after the grant; returns on the response-cycle negedge.
   task automatic transact(input string tag, input logic we, input logic [31:0] addr,
                           input logic [31:0] wd, input int unsigned waits,
                           input logic [31:0] rd);
      chk1({tag, "_req"}, mem_req, 1'b1);
      chk1({tag, "_we"}, mem_we, we);
      chk32({tag, "_addr"}, mem_addr, addr);
      if (we) chk32({tag, "_wdata"}, mem_wdata, wd);
      for (int unsigned i = 1; i < waits; i++) begin
         nclk();
         chk1({tag, "_req_hold"}, mem_req, 1'b1);
         chk32({tag, "_addr_hold"}, mem_addr, addr);
         chk32({tag, "_busy_dones"}, {29'd0, if_done, mr_done, mw_done}, 32'd0);
      end
      mem_rdata = rd;
      mem_done  = 1'b1;
      nclk();
      mem_done  = 1'b0;
      chk1({tag, "_req_drop"}, mem_req, 1'b0);
   endtask

   initial begin
      logic        exp_if;
      logic [31:0] exp_addr;

      r = 1'b0;
      if_req = 1'b0; if_cancel = 1'b0; mr_req = 1'b0; mw_req = 1'b0;
      if_addr = '0; mr_addr = '0; mw_addr = '0; mw_wdata = '0;
      mem_rdata = '0; mem_done = 1'b0;

      #3;
      chk_quiet("reset");
      chk1("reset_we", mem_we, 1'b0);
      chk32("reset_addr", mem_addr, 32'h0);
      chk32("reset_wdata", mem_wdata, 32'h0);
      chk32("reset_rdata", rdata, 32'h0);
      nclk();
      r = 1'b1;
      nclk();
      chk_quiet("idle_after_reset");

      // single MR read
      mr_req = 1'b1; mr_addr = 32'h100;
      nclk();
      transact("rd", 1'b0, 32'h100, 32'h0, 1, 32'hDEADBEEF);
      chk1("rd_done", mr_done, 1'b1);
      chk32("rd_rdata", rdata, 32'hDEADBEEF);
      mr_req = 1'b0;
      nclk();
      chk_quiet("rd_idle");

      // simultaneous requests: MW, then MR, then IF
      if_req = 1'b1; if_addr = 32'h3000;
      mr_req = 1'b1; mr_addr = 32'h200;
      mw_req = 1'b1; mw_addr = 32'h40; mw_wdata = 32'h12345678;
      nclk();
      transact("pri_mw", 1'b1, 32'h40, 32'h12345678, 1, 32'h0);
      chk32("pri_mw_done", {29'd0, if_done, mr_done, mw_done}, 32'd1);
      mw_req = 1'b0;
      nclk();
      chk_quiet("pri_gap1");
      nclk();
      transact("pri_mr", 1'b0, 32'h200, 32'h0, 1, 32'hAAAA0001);
      chk32("pri_mr_done", {29'd0, if_done, mr_done, mw_done}, 32'd2);
      chk32("pri_mr_rdata", rdata, 32'hAAAA0001);
      mr_req = 1'b0;
      nclk();
      chk_quiet("pri_gap2");
      nclk();
      transact("pri_if", 1'b0, 32'h3000, 32'h0, 1, 32'hBBBB0002);
      chk32("pri_if_done", {29'd0, if_done, mr_done, mw_done}, 32'd4);
      chk32("pri_if_rdata", rdata, 32'hBBBB0002);
      if_req = 1'b0;
      nclk();
      chk_quiet("pri_gap3");

      // fetch with 5 wait states
      if_req = 1'b1; if_addr = 32'h2000;
      nclk();
      transact("ws", 1'b0, 32'h2000, 32'h0, 5, 32'hCAFEF00D);
      chk1("ws_done", if_done, 1'b1);
      chk32("ws_rdata", rdata, 32'hCAFEF00D);
      if_req = 1'b0;
      nclk();
      chk_quiet("ws_idle");

      // fetch cancelled while BUSY, pending MR served afterwards
      if_req = 1'b1; if_addr = 32'h500;
      nclk();
      chk32("cxl_addr", mem_addr, 32'h500);
      mr_req = 1'b1; mr_addr = 32'h600;
      if_cancel = 1'b1;
      nclk();
      if_cancel = 1'b0; if_req = 1'b0;
      mem_rdata = 32'h11112222; mem_done = 1'b1;
      nclk();
      mem_done = 1'b0;
      chk1("cxl_no_done", if_done, 1'b0);
      chk32("cxl_rdata_kept", rdata, 32'hCAFEF00D);
      nclk();
      chk_quiet("cxl_idle");
      nclk();
      transact("cxl_mr", 1'b0, 32'h600, 32'h0, 1, 32'h33334444);
      chk1("cxl_mr_done", mr_done, 1'b1);
      chk32("cxl_mr_rdata", rdata, 32'h33334444);
      mr_req = 1'b0;
      nclk();
      chk_quiet("cxl_mr_idle");

      // cancel arriving only in the response cycle
      if_req = 1'b1; if_addr = 32'hA00;
      nclk();
      transact("rcxl", 1'b0, 32'hA00, 32'h0, 1, 32'h77778888);
      if_cancel = 1'b1;
      #1;
      chk1("rcxl_no_done", if_done, 1'b0);
      chk32("rcxl_rdata", rdata, 32'h77778888);
      if_cancel = 1'b0; if_req = 1'b0;
      nclk();
      chk_quiet("rcxl_idle");

      // stray mem_done outside BUSY
      mem_done = 1'b1;
      nclk();
      mem_done = 1'b0;
      chk_quiet("stray_done");
      nclk();
      chk_quiet("stray_done2");

      // async reset during BUSY, then normal service
      mr_req = 1'b1; mr_addr = 32'h700;
      nclk();
      chk1("rst_busy_req", mem_req, 1'b1);
      #1 r = 1'b0;
      #1;
      chk_quiet("rst_async");
      chk32("rst_async_addr", mem_addr, 32'h0);
      nclk();
      r = 1'b1;
      nclk();
      transact("rst_mr", 1'b0, 32'h700, 32'h0, 1, 32'h55556666);
      chk1("rst_mr_done", mr_done, 1'b1);
      chk32("rst_mr_rdata", rdata, 32'h55556666);
      mr_req = 1'b0;
      nclk();
      chk_quiet("rst_mr_idle");

      // IF competing with a continuous MR stream
      if_req = 1'b1; if_addr = 32'h9000;
      mr_req = 1'b1; mr_addr = 32'h800;
      for (int k = 0; k < 4; k++) begin
`ifdef ARB_FETCH_AGE_EN
         exp_if = (k == 2);
`else
         exp_if = (k == 3);
         if (k == 3) mr_req = 1'b0;
`endif
         exp_addr = exp_if ? 32'h9000 : 32'h800;
         nclk();
         transact("age", 1'b0, exp_addr, 32'h0, 1, 32'hF0 + 32'(k));
         if (exp_if) begin
            chk1("age_if_done", if_done, 1'b1);
            if_req = 1'b0;
         end else begin
            chk1("age_mr_done", mr_done, 1'b1);
            chk1("age_if_starved", if_done, 1'b0);
         end
         chk32("age_rdata", rdata, 32'hF0 + 32'(k));
         nclk();
         chk_quiet("age_gap");
      end
      if_req = 1'b0; mr_req = 1'b0;
      nclk();
      nclk();
      chk_quiet("final_idle");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single-ported data/instruction memory between three requesters: instruction fetch (IF), the memory-read stage (MR) and the memory-writeback stage (MW). It arbitrates, drives one memory transaction at a time through a req/done handshake, returns read data, and pulses a per-requester done. The pipeline derives mr_stall / mw_stall / fetch stall from req & !done.

Parameters:
ADDR_W, 32, address width for all requesters and the memory port
DATA_W, 32, read/write data width
AGE_LIMIT, 4, consecutive IF arbitration losses before forced IF grant; used only with ARB_FETCH_AGE_EN

Ports:
clk  in  1  clock, rising edge
r  in  1  reset, asynchronous, active-low
if_req  in  1  fetch read request, held until if_done or if_cancel
if_addr  in  ADDR_W  fetch address
if_cancel  in  1  fetch redirect (jump); squashes the pending or in-flight fetch
mr_req  in  1  MR-stage read request
mr_addr  in  ADDR_W  MR read address
mw_req  in  1  MW-stage write request
mw_addr  in  ADDR_W  MW write address
mw_wdata  in  DATA_W  MW write data
if_done  out  1  one-cycle pulse: fetch complete, rdata valid
mr_done  out  1  one-cycle pulse: MR read complete, rdata valid
mw_done  out  1  one-cycle pulse: write complete
rdata  out  DATA_W  registered read data, valid with if_done/mr_done
mem_req  out  1  memory request, held until mem_done
mem_we  out  1  1 = write, 0 = read
mem_addr  out  ADDR_W  registered transaction address
mem_wdata  out  DATA_W  registered write data
mem_rdata  in  DATA_W  memory read data, valid with mem_done
mem_done  in  1  memory completion, one cycle, only while mem_req=1

Behaviour:
- Reset (r=0, async): state IDLE; mem_req, mem_we, if_done, mr_done, mw_done = 0; mem_addr, mem_wdata, rdata = 0; owner = NONE; cancel flag = 0. Reset mid-transaction drops mem_req immediately. No done pulse for the aborted transaction.
- FSM states:
  - IDLE, BUSY, RESP.
  - IDLE: if any req, latch winner into owner, addr/we/wdata into mem_* regs, go BUSY. Otherwise stay IDLE.
  - BUSY: mem_req=1. On mem_done: rdata <= mem_rdata (reads only), go RESP.
  - RESP: mem_req=0. Assert owner's done for exactly this cycle, then go IDLE.
- Priority (strict, oldest instruction first): MW > MR > IF. Arbitration happens only in IDLE; a granted transaction is never pre-empted.
- Latency: req sampled in IDLE at cycle N. mem_req is high from cycle N+1. If mem_done arrives at cycle N+k (k>=1), done is high at cycle N+k+1. Minimum is 2 cycles.
- Back-to-back: RESP always returns to IDLE, so there is at least 1 idle cycle between transactions. Max throughput is one transaction per 3 cycles with a 1-cycle memory.
- Requester rule: the requester deasserts req in the cycle after its done; IDLE must not see a stale req. The requester holds addr/wdata stable only until the grant; the arbiter registers them.
- if_cancel:
  - IF not granted: the request is ignored while if_cancel=1.
  - IF owner in BUSY: set cancel flag. The memory transaction completes normally, but if_done is suppressed in RESP and rdata is not updated.
  - IF owner in RESP with if_cancel=1 that cycle: if_done is suppressed.
  - The cancel flag clears on entry to IDLE.
- mem_done while not in BUSY is ignored.
- Done pulses are mutually exclusive: at most one of if_done/mr_done/mw_done is high in any cycle.

Optional Feature:
ARB_FETCH_AGE_EN
- Defined: a counter (width clog2(AGE_LIMIT+1)) increments each time IF is requesting in IDLE and loses arbitration. When count == AGE_LIMIT, the next IDLE arbitration grants IF over MR/MW. The counter clears on IF grant, on if_req=0, on if_cancel, and on reset.
- Undefined: strict MW > MR > IF, no counter logic.

Test Plan:
- Single read: mr_req=1, mr_addr=0x100, memory returns 0xDEADBEEF with 1-cycle mem_done -> mem_req high 1 cycle, mem_we=0; mr_done and rdata=0xDEADBEEF 2 cycles after req.
- Priority: if_req, mr_req, mw_req all asserted at the same cycle (mw_addr=0x40, wdata=0x12345678) -> grant order MW, MR, IF. mw_done precedes mr_done precedes if_done. Each done occurs once, one cycle wide.
- Memory wait states: mem_done delayed 5 cycles on a fetch at 0x2000 -> mem_req/mem_addr stable for all 5 cycles; if_done exactly 1 cycle after mem_done.
- Fetch cancel: IF granted, if_cancel=1 during BUSY, mem_done arrives -> no if_done, rdata unchanged. Next pending mr_req is granted at the following IDLE.
- Async reset in BUSY: r=0 mid-transaction -> mem_req=0 and all done=0 with no clock edge. After release, state IDLE and a new mr_req is serviced normally.
- With ARB_FETCH_AGE_EN, AGE_LIMIT=2: hold if_req while MR/MW requests are continuous -> IF is granted on the 3rd arbitration. Without the macro, IF starves while MR/MW requests persist.
